// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divider issue unit:
//   - div_state_e : issue FSM states
//   - DEF_WIDTH   : default operand/quotient width
//   - DEF_TAG_W   : default request tag width
//   - DIV_DZ_Q    : quotient returned for a divide-by-zero (all ones)
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 4;

    localparam logic [DEF_WIDTH-1:0] DIV_DZ_Q = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_req_fifo.sv
// ----------------------------------------------------------------------------
// div_req_fifo
// Synchronous request FIFO. Pointers carry one extra wrap bit so that a full
// FIFO (same index, different wrap) is distinguished from an empty one.
// A push while full is dropped even if a pop happens in the same cycle.
// Ports:
//   ck, rst      clock (rising edge), asynchronous active-high reset
//   din          entry to write ({a, b, tag} packed by the caller)
//   push, pop    write / read strobes (ignored when full / empty)
//   full, empty  occupancy flags
//   head         oldest entry, valid when !empty
// ----------------------------------------------------------------------------
module div_req_fifo #(
    parameter int DW    = 68,
    parameter int DEPTH = 4
) (
    input  logic          ck,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          push,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block ordering.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge ck) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/div_issue_unit.sv
// ----------------------------------------------------------------------------
// div_issue_unit
// Front end for the iterative divider. Requests are queued in div_req_fifo
// and launched one at a time: IDLE pops a request, ISSUE pulses div_start,
// WAIT holds the operands until div_finished (or a watchdog abort), and RESP
// presents the result until the consumer takes it. A zero divisor skips the
// divider and answers immediately with an all-ones quotient and rsp_dz set.
// Ports:
//   ck, rst                       clock, asynchronous active-high reset
//   req_valid/ready, req_a/b/tag  request port (ready = FIFO not full)
//   div_a, div_b, div_start       divider launch, operands stable ISSUE..WAIT
//   div_q, div_finished           divider result
//   rsp_valid/ready, rsp_q/tag    response port
//   rsp_dz, rsp_to                divide-by-zero / watchdog-abort flags
//   busy                          FSM active or requests queued
// ----------------------------------------------------------------------------
module div_issue_unit
    import div_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int TIMEOUT = 64
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output logic             div_start,
    input  logic [WIDTH-1:0] div_q,
    input  logic             div_finished,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_q,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_dz,
    output logic             rsp_to,
    output logic             busy
);

    localparam int FW   = 2*WIDTH + TAG_W;
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    // Widen the package constant to this instance's width.
    localparam logic [WIDTH-1:0] DZ_Q    = {WIDTH{DIV_DZ_Q[0]}};

    // FIFO interface
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [FW-1:0]    fifo_head;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [TAG_W-1:0] head_tag;

    // Working / response registers and their next values
    div_state_e       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [TAG_W-1:0] tag_q,    tag_d;
    logic [WIDTH-1:0] q_q,      q_d;
    logic             dz_q,     dz_d;
    logic             to_q,     to_d;
    logic [WD_W-1:0]  wdog_q,   wdog_d;

    div_req_fifo #(
        .DW    (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ck    (ck),
        .rst   (rst),
        .din   ({req_a, req_b, req_tag}),
        .push  (req_valid),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign {head_a, head_b, head_tag} = fifo_head;

    // ---------------- next-state / datapath ----------------
    // NOTE: every signal driven here gets its default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        q_d      = q_q;
        dz_d     = dz_q;
        to_d     = to_q;
        wdog_d   = wdog_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    a_d      = head_a;
                    b_d      = head_b;
                    tag_d    = head_tag;
                    if (head_b == '0) begin
                        // Answer locally; the divider never sees this request.
                        q_d     = DZ_Q;
                        dz_d    = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A finish on the abort cycle still delivers the real quotient.
                if (div_finished) begin
                    q_d     = div_q;
                    state_d = RESP;
                end else if (wdog_q == WD_LAST) begin
                    to_d    = 1'b1;
                    q_d     = '0;
                    state_d = RESP;
                end else begin
                    wdog_d  = wdog_q + WD_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    dz_d    = 1'b0;
                    to_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            q_q     <= '0;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            q_q     <= q_d;
            dz_q    <= dz_d;
            to_q    <= to_d;
            wdog_q  <= wdog_d;
        end
    end

    // ---------------- outputs (decoded from registers only) ----------------
    assign req_ready = !fifo_full;
    assign div_a     = a_q;
    assign div_b     = b_q;
    assign div_start = (state_q == ISSUE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_q     = q_q;
    assign rsp_tag   = tag_q;
    assign rsp_dz    = dz_q;
    assign rsp_to    = to_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_div_issue_unit.sv
// ----------------------------------------------------------------------------
// tb_div_issue_unit
// Directed bench for div_issue_unit with a behavioural divider that returns
// A/B with a one-cycle finished pulse 33 cycles after it sees div_start.
// ----------------------------------------------------------------------------
module tb_div_issue_unit;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_tag = '0;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_start;
    logic [31:0] div_q = '0;
    logic        div_finished = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_q;
    logic [3:0]  rsp_tag;
    logic        rsp_dz;
    logic        rsp_to;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    div_issue_unit #(
        .WIDTH   (32),
        .DEPTH   (4),
        .TAG_W   (4),
        .TIMEOUT (64)
    ) dut (
        .ck           (ck),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_tag      (req_tag),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_start    (div_start),
        .div_q        (div_q),
        .div_finished (div_finished),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_q        (rsp_q),
        .rsp_tag      (rsp_tag),
        .rsp_dz       (rsp_dz),
        .rsp_to       (rsp_to),
        .busy         (busy)
    );

    always #5 ck = ~ck;

    // ---------------- behavioural divider ----------------
    // Works on the falling edge so the DUT sees stable inputs at posedge.
    // It ignores rst on purpose: a divide dropped by reset still "finishes".
    bit          model_en = 1'b1;
    bit          m_run    = 1'b0;
    int          m_cnt    = 0;
    logic [31:0] m_a, m_b;
    int          n_start  = 0;

    always @(negedge ck) begin
        div_finished = 1'b0;
        if (div_start) n_start++;
        if (div_start && !m_run) begin
            m_run = 1'b1;
            m_cnt = 0;
            m_a   = div_a;
            m_b   = div_b;
        end else if (m_run) begin
            m_cnt++;
            if (m_cnt == 33) begin
                m_run = 1'b0;
                if (model_en) begin
                    div_q        = m_a / m_b;
                    div_finished = 1'b1;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        int n = 0;
        req_a = a; req_b = b; req_tag = t; req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            @(negedge ck);
            n++;
        end
        check("push_ready", req_ready, 1);
        @(posedge ck);
        @(negedge ck);
        req_valid = 1'b0;
    endtask

    // Waits (on falling edges) for rsp_valid; n = falling edges waited.
    task automatic wait_rsp(input string tag, input int limit, output int n);
        n = 0;
        while (!rsp_valid && n < limit) begin
            @(negedge ck);
            n++;
        end
        check(tag, rsp_valid, 1);
    endtask

    // Accept the current response with a one-cycle rsp_ready.
    task automatic accept();
        rsp_ready = 1'b1;
        @(posedge ck);
        @(negedge ck);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [31:0] va [6] = '{32'd20, 32'd21, 32'd9, 32'd30, 32'd8, 32'd99};
    logic [31:0] vb [6] = '{32'd5,  32'd7,  32'd0, 32'd3,  32'd8, 32'd9};
    logic [3:0]  vt [6] = '{4'd1,   4'd2,   4'd3,  4'd4,   4'd5,  4'd6};
    logic [31:0] eq [5] = '{32'd4,  32'd3,  32'hFFFF_FFFF, 32'd10, 32'd1};
    logic        ed [5] = '{1'b0,   1'b0,   1'b1,  1'b0,   1'b0};

    initial begin
        int lat;
        int acc;
        int starts0;
        bit rdy;
        bit saw_valid;
        bit saw_fin;

        // ---- reset ----
        repeat (2) @(negedge ck);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_div_start", div_start, 0);
        check("rst_busy",      busy,      0);
        rst = 1'b0;
        @(negedge ck);
        check("post_rst_div_a", div_a, 0);
        check("post_rst_rsp_q", rsp_q, 0);

        // ---- 1: 0xC / 0x4 ----
        starts0 = n_start;
        push(32'hC, 32'h4, 4'd1);
        check("t1_busy_queued", busy, 1);
        check("t1_start_before", div_start, 0);
        @(negedge ck);
        check("t1_start", div_start, 1);
        check("t1_div_a", div_a, 32'hC);
        check("t1_div_b", div_b, 32'h4);
        @(negedge ck);
        check("t1_start_one_cycle", div_start, 0);
        lat = 1;
        begin
            int n;
            wait_rsp("t1_rsp_seen", 200, n);
            lat += n;
        end
        check("t1_latency", lat, 34);
        check("t1_q",   rsp_q,   32'h3);
        check("t1_tag", rsp_tag, 4'd1);
        check("t1_dz",  rsp_dz,  0);
        check("t1_to",  rsp_to,  0);
        accept();
        check("t1_rsp_done", rsp_valid, 0);
        check("t1_starts", n_start - starts0, 1);

        // ---- 2: back-to-back ----
        starts0 = n_start;
        rsp_ready = 1'b1;
        push(32'hF,  32'h6, 4'd2);
        push(32'h64, 32'hA, 4'd3);
        wait_rsp("t2a_rsp_seen", 200, lat);
        check("t2a_q",   rsp_q,   32'h2);
        check("t2a_tag", rsp_tag, 4'd2);
        @(negedge ck);
        wait_rsp("t2b_rsp_seen", 200, lat);
        check("t2b_q",   rsp_q,   32'hA);
        check("t2b_tag", rsp_tag, 4'd3);
        @(negedge ck);
        rsp_ready = 1'b0;
        check("t2_starts", n_start - starts0, 2);

        // ---- 3: divide by zero ----
        starts0 = n_start;
        push(32'h5, 32'h0, 4'd7);
        @(negedge ck);
        check("t3_valid_at_e1", rsp_valid, 1);
        check("t3_q",   rsp_q,   32'hFFFF_FFFF);
        check("t3_dz",  rsp_dz,  1);
        check("t3_to",  rsp_to,  0);
        check("t3_tag", rsp_tag, 4'd7);
        accept();
        check("t3_dz_cleared", rsp_dz, 0);
        check("t3_no_start", n_start - starts0, 0);

        // ---- 4: backpressure, capacity DEPTH+1 ----
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge ck);
            req_a = va[acc]; req_b = vb[acc]; req_tag = vt[acc]; req_valid = 1'b1;
            rdy = req_ready;
            @(posedge ck);
            if (rdy) acc++;
        end
        @(negedge ck);
        req_valid = 1'b0;
        check("t4_accepted", acc, 5);
        check("t4_req_ready_full", req_ready, 0);
        wait_rsp("t4_first_seen", 200, lat);
        for (int s = 0; s < 3; s++) begin
            check("t4_stall_q",   rsp_q,   32'd4);
            check("t4_stall_tag", rsp_tag, 4'd1);
            @(negedge ck);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp("t4_drain_seen", 200, lat);
            check("t4_drain_q",   rsp_q,   eq[i]);
            check("t4_drain_tag", rsp_tag, vt[i]);
            check("t4_drain_dz",  rsp_dz,  ed[i]);
            @(negedge ck);
        end
        rsp_ready = 1'b0;
        check("t4_idle", busy, 0);

        // ---- 5: watchdog abort ----
        model_en = 1'b0;
        push(32'h30, 32'h6, 4'd9);
        @(negedge ck);
        check("t5_start", div_start, 1);
        @(negedge ck);
        check("t5_busy_wait", busy, 1);
        lat = 1;
        begin
            int n;
            wait_rsp("t5_rsp_seen", 200, n);
            lat += n;
        end
        check("t5_latency", lat, 65);
        check("t5_to",  rsp_to,  1);
        check("t5_q",   rsp_q,   0);
        check("t5_dz",  rsp_dz,  0);
        check("t5_tag", rsp_tag, 4'd9);
        accept();
        check("t5_to_cleared", rsp_to, 0);
        model_en = 1'b1;
        push(32'h51, 32'h9, 4'hA);
        wait_rsp("t5b_rsp_seen", 200, lat);
        check("t5b_q",  rsp_q,   32'h9);
        check("t5b_to", rsp_to,  0);
        check("t5b_tag", rsp_tag, 4'hA);
        accept();

        // ---- 6: reset mid-WAIT ----
        starts0 = n_start;
        push(32'h40, 32'h8, 4'hB);
        push(32'h10, 32'h2, 4'hC);
        repeat (5) @(negedge ck);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy",      busy,      0);
        check("t6_rst_req_ready", req_ready, 1);
        check("t6_rst_div_a",     div_a,     0);
        check("t6_rst_div_b",     div_b,     0);
        check("t6_rst_rsp_valid", rsp_valid, 0);
        @(negedge ck);
        rst = 1'b0;
        rsp_ready = 1'b1;
        saw_valid = 1'b0;
        saw_fin   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge ck);
            #1;
            if (rsp_valid)    saw_valid = 1'b1;
            if (div_finished) saw_fin   = 1'b1;
        end
        check("t6_late_finished_seen", saw_fin,   1);
        check("t6_no_rsp",             saw_valid, 0);
        check("t6_starts",             n_start - starts0, 1);
        check("t6_busy",               busy,      0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
